// File: rtl/id_stage.sv
// ============================================================================
// id_stage : MIPS decode/issue stage with operand bypass and load-use bubble
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module id_stage #(
  parameter int ALU_OPC_WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     if_valid,
  input  logic [31:0]              inst_word,
  input  logic [31:0]              inst_pc,
  output logic                     id_ready,
  input  logic                     flush,
  input  logic                     ex_stall,
  output logic [4:0]               rf_raddr_a,
  output logic [4:0]               rf_raddr_b,
  input  logic [31:0]              rf_rdata_a,
  input  logic [31:0]              rf_rdata_b,
  input  logic                     ex_fwd_valid,
  input  logic [4:0]               ex_fwd_reg,
  input  logic [31:0]              ex_fwd_data,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_reg,
  input  logic [31:0]              wb_data,
  output logic                     ex_valid,
  output logic [31:0]              pc,
  output logic [31:0]              A,
  output logic [31:0]              B,
  output logic [4:0]               A_reg,
  output logic [4:0]               B_reg,
  output logic                     B_imm,
  output logic [4:0]               shamt,
  output logic [31:0]              imm,
  output logic [ALU_OPC_WIDTH-1:0] alu_op,
  output logic                     alu_inst,
  output logic                     mem_inst,
  output logic                     jmp_inst,
  output logic [4:0]               dest_reg,
  output logic                     dest_reg_valid
);

  logic [5:0]  w_opc;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic        w_alu;
  logic        w_mem;
  logic        w_jmp;
  logic        w_b_imm;
  logic        w_reads_rs;
  logic        w_reads_rt;
  logic [4:0]  w_dest;
  logic [31:0] w_val_a;
  logic [31:0] w_val_b;
  logic        w_load_use;

  assign w_opc   = inst_word[31:26];
  assign w_funct = inst_word[5:0];
  assign w_rs    = inst_word[25:21];
  assign w_rt    = inst_word[20:16];
  assign w_rd    = inst_word[15:11];

  assign rf_raddr_a = w_rs;
  assign rf_raddr_b = w_rt;

  // andi/ori/xori/lui zero-extend; everything else sign-extends.
  assign w_imm = (w_opc[5:2] == 4'b0011) ? {16'h0000, inst_word[15:0]}
                                         : {{16{inst_word[15]}}, inst_word[15:0]};

  always_comb begin
    w_alu      = 1'b0;
    w_mem      = 1'b0;
    w_jmp      = 1'b0;
    w_b_imm    = 1'b0;
    w_reads_rs = 1'b0;
    w_reads_rt = 1'b0;
    w_dest     = 5'd0;
    case (w_opc)
      6'h00: begin
        w_reads_rs = 1'b1;
        if (w_funct == 6'h08 || w_funct == 6'h09) begin
          w_jmp = 1'b1;
          if (w_funct == 6'h09) w_dest = w_rd;
        end else begin
          w_alu      = 1'b1;
          w_reads_rt = 1'b1;
          w_dest     = w_rd;
        end
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        w_alu      = 1'b1;
        w_b_imm    = 1'b1;
        w_reads_rs = 1'b1;
        w_dest     = w_rt;
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: begin
        w_mem      = 1'b1;
        w_reads_rs = 1'b1;
        w_dest     = w_rt;
      end
      6'h28, 6'h29, 6'h2a, 6'h2b: begin
        w_mem      = 1'b1;
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
      end
      6'h02: w_jmp = 1'b1;
      6'h03: begin
        w_jmp  = 1'b1;
        w_dest = 5'd31;
      end
      6'h04, 6'h05: begin
        w_jmp      = 1'b1;
        w_reads_rs = 1'b1;
        w_reads_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // Youngest producer wins: EX result is newer than WB result.
  function automatic logic [31:0] resolve(
    input logic [4:0]  r,
    input logic [31:0] rf_val,
    input logic        exv,
    input logic [4:0]  exr,
    input logic [31:0] exd,
    input logic        wbv,
    input logic [4:0]  wbr,
    input logic [31:0] wbd
  );
    if (r == 5'd0)                return 32'd0;
    else if (exv && exr == r)     return exd;
    else if (wbv && wbr == r)     return wbd;
    else                          return rf_val;
  endfunction

  assign w_val_a = resolve(w_rs, rf_rdata_a, ex_fwd_valid, ex_fwd_reg, ex_fwd_data,
                           wb_valid, wb_reg, wb_data);
  assign w_val_b = resolve(w_rt, rf_rdata_b, ex_fwd_valid, ex_fwd_reg, ex_fwd_data,
                           wb_valid, wb_reg, wb_data);

  // Only loads carry both mem_inst and a valid dest.
  assign w_load_use = if_valid && ex_valid && mem_inst && dest_reg_valid &&
                      ((w_reads_rs && w_rs == dest_reg) ||
                       (w_reads_rt && w_rt == dest_reg));

  assign id_ready = flush || (!ex_stall && !w_load_use);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid       <= 1'b0;
      pc             <= 32'd0;
      A              <= 32'd0;
      B              <= 32'd0;
      A_reg          <= 5'd0;
      B_reg          <= 5'd0;
      B_imm          <= 1'b0;
      shamt          <= 5'd0;
      imm            <= 32'd0;
      alu_op         <= '0;
      alu_inst       <= 1'b0;
      mem_inst       <= 1'b0;
      jmp_inst       <= 1'b0;
      dest_reg       <= 5'd0;
      dest_reg_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else if (!if_valid || w_load_use) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid       <= 1'b1;
      pc             <= inst_pc;
      A              <= w_val_a;
      B              <= w_b_imm ? w_imm : w_val_b;
      A_reg          <= w_rs;
      B_reg          <= w_rt;
      B_imm          <= w_b_imm;
      shamt          <= inst_word[10:6];
      imm            <= w_imm;
      // funct only qualifies R-type opcodes; other formats carry zero there.
      alu_op         <= {w_opc, (w_opc == 6'h00) ? w_funct : 6'h00};
      alu_inst       <= w_alu;
      mem_inst       <= w_mem;
      jmp_inst       <= w_jmp;
      dest_reg       <= w_dest;
      dest_reg_valid <= (w_dest != 5'd0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// tb_id_stage : directed + randomized check of id_stage against a decode model
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_id_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_valid;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic        id_ready;
  logic        flush;
  logic        ex_stall;
  logic [4:0]  rf_raddr_a;
  logic [4:0]  rf_raddr_b;
  logic [31:0] rf_rdata_a;
  logic [31:0] rf_rdata_b;
  logic        ex_fwd_valid;
  logic [4:0]  ex_fwd_reg;
  logic [31:0] ex_fwd_data;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] pc;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  A_reg;
  logic [4:0]  B_reg;
  logic        B_imm;
  logic [4:0]  shamt;
  logic [31:0] imm;
  logic [11:0] alu_op;
  logic        alu_inst;
  logic        mem_inst;
  logic        jmp_inst;
  logic [4:0]  dest_reg;
  logic        dest_reg_valid;

  always #5 clock = ~clock;

  logic [31:0] rf [32];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  id_stage #(.ALU_OPC_WIDTH(12)) dut (
    .clock(clock), .reset_n(reset_n), .if_valid(if_valid), .inst_word(inst_word),
    .inst_pc(inst_pc), .id_ready(id_ready), .flush(flush), .ex_stall(ex_stall),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a),
    .rf_rdata_b(rf_rdata_b), .ex_fwd_valid(ex_fwd_valid), .ex_fwd_reg(ex_fwd_reg),
    .ex_fwd_data(ex_fwd_data), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_valid(ex_valid), .pc(pc), .A(A), .B(B), .A_reg(A_reg), .B_reg(B_reg),
    .B_imm(B_imm), .shamt(shamt), .imm(imm), .alu_op(alu_op), .alu_inst(alu_inst),
    .mem_inst(mem_inst), .jmp_inst(jmp_inst), .dest_reg(dest_reg),
    .dest_reg_valid(dest_reg_valid)
  );

  typedef enum {K_R, K_JR, K_JALR, K_ALUI, K_LD, K_ST, K_J, K_JAL, K_BR, K_NOP} kind_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  a_reg;
    logic [4:0]  b_reg;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        b_imm;
    logic [11:0] alu_op;
    logic        alu;
    logic        mem;
    logic        jmp;
    logic        dest_v;
  } ent_t;

  ent_t exp_e;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic kind_t kind_of(input logic [31:0] w);
    logic [5:0] opc;
    opc = w[31:26];
    if (opc == 6'h00) begin
      if (w[5:0] == 6'h08) return K_JR;
      if (w[5:0] == 6'h09) return K_JALR;
      return K_R;
    end
    if (opc inside {[6'h08:6'h0f]}) return K_ALUI;
    if (opc inside {[6'h20:6'h25]}) return K_LD;
    if (opc inside {[6'h28:6'h2b]}) return K_ST;
    if (opc == 6'h02) return K_J;
    if (opc == 6'h03) return K_JAL;
    if (opc == 6'h04 || opc == 6'h05) return K_BR;
    return K_NOP;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (ex_fwd_valid && ex_fwd_reg == r) return ex_fwd_data;
    if (wb_valid && wb_reg == r) return wb_data;
    return rf[r];
  endfunction

  function automatic ent_t predict(input logic [31:0] w, input logic [31:0] p);
    ent_t  e;
    kind_t k;
    int    opc;
    int    i16;
    k   = kind_of(w);
    opc = int'(w[31:26]);
    i16 = int'(w[15:0]);
    e = '0;
    e.valid  = 1'b1;
    e.pc     = p;
    e.a_reg  = w[25:21];
    e.b_reg  = w[20:16];
    e.shamt  = w[10:6];
    if (opc >= 12 && opc <= 15) e.imm = i16;
    else                        e.imm = (i16 >= 32768) ? i16 - 65536 : i16;
    e.alu_op = (opc * 64 + ((opc == 0) ? int'(w[5:0]) : 0));
    e.a = opnd(w[25:21]);
    e.b = opnd(w[20:16]);
    case (k)
      K_R:    begin e.alu = 1; e.dest = w[15:11]; end
      K_JR:   e.jmp = 1;
      K_JALR: begin e.jmp = 1; e.dest = w[15:11]; end
      K_ALUI: begin e.alu = 1; e.b_imm = 1; e.b = e.imm; e.dest = w[20:16]; end
      K_LD:   begin e.mem = 1; e.dest = w[20:16]; end
      K_ST:   e.mem = 1;
      K_J:    e.jmp = 1;
      K_JAL:  begin e.jmp = 1; e.dest = 5'd31; end
      K_BR:   e.jmp = 1;
      default: ;
    endcase
    e.dest_v = (e.dest != 0);
    return e;
  endfunction

  // A live load in ID/EX blocks any instruction that sources its target.
  function automatic logic hazard(input logic [31:0] w);
    kind_t k;
    logic  uses_rs;
    logic  uses_rt;
    if (!(exp_e.valid && exp_e.mem && exp_e.dest_v)) return 1'b0;
    k = kind_of(w);
    uses_rs = k inside {K_R, K_JR, K_JALR, K_ALUI, K_LD, K_ST, K_BR};
    uses_rt = k inside {K_R, K_ST, K_BR};
    return (uses_rs && w[25:21] == exp_e.dest) || (uses_rt && w[20:16] == exp_e.dest);
  endfunction

  task automatic compare();
    chk("ex_valid", ex_valid, exp_e.valid);
    if (exp_e.valid) begin
      chk("pc", pc, exp_e.pc);
      chk("A", A, exp_e.a);
      chk("B", B, exp_e.b);
      chk("A_reg", A_reg, exp_e.a_reg);
      chk("B_reg", B_reg, exp_e.b_reg);
      chk("B_imm", B_imm, exp_e.b_imm);
      chk("shamt", shamt, exp_e.shamt);
      chk("imm", imm, exp_e.imm);
      chk("alu_op", alu_op, exp_e.alu_op);
      chk("alu_inst", alu_inst, exp_e.alu);
      chk("mem_inst", mem_inst, exp_e.mem);
      chk("jmp_inst", jmp_inst, exp_e.jmp);
      chk("dest_reg", dest_reg, exp_e.dest);
      chk("dest_reg_valid", dest_reg_valid, exp_e.dest_v);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ex_valid"}, ex_valid, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_A"}, A, 0);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_imm"}, imm, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_flags"}, {27'd0, B_imm, alu_inst, mem_inst, jmp_inst, dest_reg_valid}, 0);
    chk({tag, "_regs"}, {17'd0, A_reg, B_reg, shamt}, 0);
    chk({tag, "_dest"}, dest_reg, 0);
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                      input logic st, input logic fl);
    logic lu;
    if_valid  = v;
    inst_word = w;
    inst_pc   = p;
    ex_stall  = st;
    flush     = fl;
    #1;
    lu = v && hazard(w);
    chk("id_ready", id_ready, fl | (!st & !lu));
    chk("rf_raddr", {22'd0, rf_raddr_a, rf_raddr_b}, {22'd0, w[25:21], w[20:16]});
    if (fl)               exp_e.valid = 1'b0;
    else if (st)          exp_e = exp_e;
    else if (!v || lu)    exp_e.valid = 1'b0;
    else                  exp_e = predict(w, p);
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic no_fwd();
    ex_fwd_valid = 0; ex_fwd_reg = 0; ex_fwd_data = 0;
    wb_valid = 0; wb_reg = 0; wb_data = 0;
  endtask

  logic [5:0]  opc_tab [24] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20,
                                6'h23, 6'h25, 6'h28, 6'h2b, 6'h3f, 6'h11, 6'h23, 6'h21};
  logic [5:0]  funct_tab [4] = '{6'h08, 6'h09, 6'h21, 6'h2a};
  logic [31:0] w_rand;
  logic [31:0] pc_hold;

  initial begin
    reset_n = 0;
    if_valid = 0; inst_word = 0; inst_pc = 0; flush = 0; ex_stall = 0;
    no_fwd();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEADBEEF;
    rf[1] = 32'd5;
    exp_e = '0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset_n = 1;

    // addiu $2,$1,-1
    step(1, 32'h2422FFFF, 32'h100, 0, 0);
    chk("addiu_alu_op", alu_op, 32'h240);
    chk("addiu_A", A, 32'd5);
    chk("addiu_B", B, 32'hFFFFFFFF);
    chk("addiu_dest", {26'd0, B_imm, dest_reg_valid, dest_reg}, {26'd0, 1'b1, 1'b1, 5'd2});

    // lw $3,0($1) ; addu $4,$3,$3
    step(1, 32'h8C230000, 32'h104, 0, 0);
    step(1, 32'h00632021, 32'h108, 0, 0);
    chk("lu_bubble", ex_valid, 0);
    ex_fwd_valid = 1; ex_fwd_reg = 3; ex_fwd_data = 32'h1234;
    step(1, 32'h00632021, 32'h108, 0, 0);
    chk("lu_issue_A", A, 32'h1234);
    chk("lu_issue_B", B, 32'h1234);
    no_fwd();

    // ori $0,$1,0x8000 ; addu $5,$0,$1
    step(1, 32'h34208000, 32'h10C, 0, 0);
    chk("ori_B", B, 32'h00008000);
    chk("ori_dest_valid", dest_reg_valid, 0);
    step(1, 32'h00012821, 32'h110, 0, 0);
    chk("r0_A", A, 32'd0);

    // three stalled cycles then release
    step(1, 32'h00E04021, 32'h114, 0, 0);
    pc_hold = pc;
    repeat (3) step(1, 32'h2422FFFF, 32'h118, 1, 0);
    chk("stall_hold_pc", pc, pc_hold);
    step(1, 32'h2422FFFF, 32'h118, 0, 0);
    chk("stall_release_pc", pc, 32'h118);
    step(0, 32'h0, 32'h0, 0, 0);
    chk("no_dup", ex_valid, 0);

    // flush beats stall and a pending load-use
    step(1, 32'h8C230000, 32'h11C, 0, 0);
    step(1, 32'h00632021, 32'h120, 1, 1);
    chk("flush_kill", ex_valid, 0);

    // EX and WB both target rs=7
    ex_fwd_valid = 1; ex_fwd_reg = 7; ex_fwd_data = 32'h11;
    wb_valid = 1; wb_reg = 7; wb_data = 32'h22;
    step(1, 32'h00E04021, 32'h124, 0, 0);
    chk("ex_over_wb_A", A, 32'h11);
    no_fwd();

    // reset asserted in the middle of a stall
    step(1, 32'h8C230000, 32'h128, 0, 0);
    step(1, 32'h00632021, 32'h12C, 1, 0);
    reset_n = 0;
    #1;
    check_zero("midstall");
    exp_e = '0;
    @(posedge clock);
    #1;
    reset_n = 1;

    for (int n = 0; n < 400; n++) begin
      if ((n % 50) == 0) begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
      end
      w_rand = {opc_tab[$urandom_range(0, 23)], 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 16'($urandom)};
      if (w_rand[31:26] == 6'h00) w_rand[5:0] = funct_tab[$urandom_range(0, 3)];
      ex_fwd_valid = 1'($urandom_range(0, 1));
      ex_fwd_reg   = 5'($urandom_range(0, 7));
      ex_fwd_data  = $urandom;
      wb_valid     = 1'($urandom_range(0, 1));
      wb_reg       = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      step(($urandom_range(0, 9) != 0), w_rand, $urandom,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
